// File: rtl/image_pipe_if.sv
// Image-pipe streaming link: data, valid, last beat of frame and backpressure.
// The master drives the beat; the slave returns busy.
interface image_pipe_if #(
  parameter int DATA_W = 32
) ();
  logic [DATA_W-1:0] data;
  logic              valid;
  logic              last;
  logic              busy;

  modport master (output data, valid, last, input busy);
  modport slave  (input data, valid, last, output busy);
endinterface

// File: rtl/image_pipe_stage.sv
// Per-pixel op stage (pass/add/invert/threshold) with an output FIFO on the image-pipe link.
// Define IMAGE_PIPE_SAT_EN to make the mode-1 add saturate instead of wrap.
module image_pipe_stage #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4,
  parameter int FCNT_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  image_pipe_if.slave       s_if,
  image_pipe_if.master      m_if,
  input  logic [1:0]        cfg_mode,
  input  logic [DATA_W-1:0] cfg_offset,
  input  logic [DATA_W-1:0] cfg_thresh,
  output logic [FCNT_W-1:0] frame_cnt_out,
  output logic              overflow_out
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic              last;
    logic [DATA_W-1:0] data;
  } beat_t;

  typedef enum logic {IDLE, IN_FRAME} state_t;

  state_t            state;
  logic [1:0]        sh_mode;
  logic [DATA_W-1:0] sh_offset, sh_thresh;

  beat_t             mem [DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [CW-1:0]     count, count_next;
  logic              push, pop;

  logic [1:0]        eff_mode;
  logic [DATA_W-1:0] eff_offset, eff_thresh, result;
  beat_t             wr_beat;
  beat_t             head;

`ifdef IMAGE_PIPE_SAT_EN
  logic [DATA_W:0]   sum_ext;
  assign sum_ext = {1'b0, s_if.data} + {1'b0, eff_offset};
`endif

  // The output register frees up either when empty or when its beat transfers this edge.
  always_comb begin
    pop        = (count != '0) && (!m_if.valid || !m_if.busy);
    push       = s_if.valid && ((count < CW'(DEPTH)) || pop);
    count_next = count + CW'(push) - CW'(pop);
    head       = mem[rd_ptr];
  end

  // The first beat of a frame sees the live config; the rest see the shadow copy.
  always_comb begin
    eff_mode   = (state == IDLE) ? cfg_mode   : sh_mode;
    eff_offset = (state == IDLE) ? cfg_offset : sh_offset;
    eff_thresh = (state == IDLE) ? cfg_thresh : sh_thresh;
    result     = s_if.data;
    case (eff_mode)
      2'd1: begin
`ifdef IMAGE_PIPE_SAT_EN
        result = sum_ext[DATA_W] ? '1 : sum_ext[DATA_W-1:0];
`else
        result = s_if.data + eff_offset;
`endif
      end
      2'd2:    result = ~s_if.data;
      2'd3:    result = (s_if.data >= eff_thresh) ? '1 : '0;
      default: result = s_if.data;
    endcase
    wr_beat = '{last: s_if.last, data: result};
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_beat;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      sh_mode       <= '0;
      sh_offset     <= '0;
      sh_thresh     <= '0;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      s_if.busy     <= 1'b0;
      m_if.data     <= '0;
      m_if.valid    <= 1'b0;
      m_if.last     <= 1'b0;
      frame_cnt_out <= '0;
      overflow_out  <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count_next;
      // One spare entry absorbs the beat already in flight when busy is seen upstream.
      s_if.busy <= (count_next >= CW'(DEPTH - 1));
      if (s_if.valid && !push) overflow_out <= 1'b1;

      if (pop) begin
        m_if.data  <= head.data;
        m_if.last  <= head.last;
        m_if.valid <= 1'b1;
      end else if (!m_if.busy) begin
        m_if.valid <= 1'b0;
      end

      if (m_if.valid && !m_if.busy && m_if.last) frame_cnt_out <= frame_cnt_out + FCNT_W'(1);

      case (state)
        IDLE: if (push) begin
          sh_mode   <= cfg_mode;
          sh_offset <= cfg_offset;
          sh_thresh <= cfg_thresh;
          if (!s_if.last) state <= IN_FRAME;
        end
        IN_FRAME: if (push && s_if.last) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_image_pipe_stage.sv
// Self-checking bench for image_pipe_stage: vector table plus hand sequences, scoreboard on output.
module tb_image_pipe_stage;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  image_pipe_if #(.DATA_W(DW)) s_if ();
  image_pipe_if #(.DATA_W(DW)) m_if ();

  logic [1:0]    cfg_mode;
  logic [DW-1:0] cfg_offset, cfg_thresh;
  logic [15:0]   frame_cnt;
  logic          overflow;

  image_pipe_stage #(.DATA_W(DW), .DEPTH(4), .FCNT_W(16)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .s_if         (s_if),
    .m_if         (m_if),
    .cfg_mode     (cfg_mode),
    .cfg_offset   (cfg_offset),
    .cfg_thresh   (cfg_thresh),
    .frame_cnt_out(frame_cnt),
    .overflow_out (overflow)
  );

  int checks = 0;
  int errors = 0;
  int exp_fc = 0;
  logic [DW:0] exp_q[$];
  logic [DW:0] mon_e;

  typedef struct {
    logic [1:0]    mode;
    logic [DW-1:0] off;
    logic [DW-1:0] thr;
    logic [DW-1:0] pix;
    logic [DW-1:0] exp_wrap;
    logic [DW-1:0] exp_sat;
  } vec_t;
  vec_t tv[8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Scoreboard: every transfer on the master side must match the oldest expected beat.
  always @(negedge clk) begin
    if (rst_n && m_if.valid && !m_if.busy) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL out_unexpected actual=%0h required=none", {m_if.last, m_if.data});
      end else begin
        mon_e = exp_q.pop_front();
        chk("out_beat", {31'b0, m_if.last, m_if.data}, {31'b0, mon_e});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [DW-1:0] pix, input logic last,
                      input logic [DW-1:0] exp_pix, input bit keep);
    s_if.valid = 1'b1;
    s_if.data  = pix;
    s_if.last  = last;
    if (keep) begin
      exp_q.push_back({last, exp_pix});
      if (last) exp_fc++;
    end
    tick();
    s_if.valid = 1'b0;
    s_if.last  = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      tick();
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout actual=%0d beats left required=0", exp_q.size());
      exp_q.delete();
    end
    tick();
    tick();
  endtask

  initial begin
    int sent;
    bit seen_busy;
    logic [DW-1:0] e;

    s_if.valid = 1'b0; s_if.last = 1'b0; s_if.data = '0;
    m_if.busy  = 1'b0;
    cfg_mode = 2'd0; cfg_offset = '0; cfg_thresh = '0;

    repeat (2) tick();
    chk("rst_valid", m_if.valid, 0);
    chk("rst_data", m_if.data, 0);
    chk("rst_busy", s_if.busy, 0);
    chk("rst_fcnt", frame_cnt, 0);
    chk("rst_ovf", overflow, 0);
    rst_n = 1'b1;
    tick();

    // Single-beat frames: each uses the live config, so the FSM must stay IDLE between them.
    tv[0] = '{2'd0, 32'h0,        32'h0,  32'h12345678, 32'h12345678, 32'h12345678};
    tv[1] = '{2'd1, 32'h5,        32'h0,  32'h0000000A, 32'h0000000F, 32'h0000000F};
    tv[2] = '{2'd1, 32'h1,        32'h0,  32'hFFFFFFFF, 32'h00000000, 32'hFFFFFFFF};
    tv[3] = '{2'd2, 32'h0,        32'h0,  32'h0F0F0000, 32'hF0F0FFFF, 32'hF0F0FFFF};
    tv[4] = '{2'd3, 32'h0,        32'h80, 32'h0000007F, 32'h00000000, 32'h00000000};
    tv[5] = '{2'd3, 32'h0,        32'h80, 32'h00000080, 32'hFFFFFFFF, 32'hFFFFFFFF};
    tv[6] = '{2'd3, 32'h0,        32'h80, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF};
    tv[7] = '{2'd1, 32'h80000000, 32'h0,  32'h80000001, 32'h00000001, 32'hFFFFFFFF};
    for (int i = 0; i < 8; i++) begin
      cfg_mode = tv[i].mode; cfg_offset = tv[i].off; cfg_thresh = tv[i].thr;
`ifdef IMAGE_PIPE_SAT_EN
      e = tv[i].exp_sat;
`else
      e = tv[i].exp_wrap;
`endif
      beat(tv[i].pix, 1'b1, e, 1'b1);
    end
    drain();
    chk("fcnt_table", frame_cnt, exp_fc);

    // Add-1 frame with wrap on the last beat; also checks the one-cycle latency.
    cfg_mode = 2'd1; cfg_offset = 32'h1;
    beat(32'h0, 1'b0, 32'h1, 1'b1);
    chk("lat_not_yet", m_if.valid, 0);
    beat(32'h1, 1'b0, 32'h2, 1'b1);
    chk("lat_valid", m_if.valid, 1);
    chk("lat_data", m_if.data, 32'h1);
    beat(32'h2, 1'b0, 32'h3, 1'b1);
`ifdef IMAGE_PIPE_SAT_EN
    beat(32'hFFFFFFFF, 1'b1, 32'hFFFFFFFF, 1'b1);
`else
    beat(32'hFFFFFFFF, 1'b1, 32'h0, 1'b1);
`endif
    drain();
    chk("fcnt_add", frame_cnt, exp_fc);

    // Streaming with downstream stall; producer honours busy.
    cfg_mode = 2'd0;
    sent = 0;
    seen_busy = 1'b0;
    for (int c = 0; c < 80 && sent < 16; c++) begin
      m_if.busy = (c >= 3 && c <= 10);
      if (s_if.busy) seen_busy = 1'b1;
      if (!s_if.busy) begin
        beat(32'h1000 + sent, sent == 15, 32'h1000 + sent, 1'b1);
        sent++;
      end else begin
        tick();
      end
    end
    m_if.busy = 1'b0;
    chk("stream_sent", sent, 16);
    drain();
    chk("stream_ovf", overflow, 0);
    chk("stream_busy_seen", seen_busy, 1);
    chk("stream_fcnt", frame_cnt, exp_fc);

    // Producer ignores busy while downstream is stalled: 5 beats kept, rest dropped.
    m_if.busy = 1'b1;
    for (int i = 0; i < 8; i++) beat(32'h200 + i, i == 4, 32'h200 + i, i < 5);
    chk("ovf_set", overflow, 1);
    chk("ovf_busy", s_if.busy, 1);
    chk("ovf_held_data", m_if.data, 32'h200);
    m_if.busy = 1'b0;
    drain();
    chk("ovf_sticky", overflow, 1);
    chk("ovf_fcnt", frame_cnt, exp_fc);

    // Mid-frame mode change applies only from the next frame.
    cfg_mode = 2'd2; cfg_thresh = 32'h80;
    beat(32'h7F, 1'b0, ~32'h7F, 1'b1);
    cfg_mode = 2'd3;
    beat(32'h80, 1'b0, ~32'h80, 1'b1);
    beat(32'h55, 1'b1, ~32'h55, 1'b1);
    beat(32'h7F, 1'b0, 32'h0, 1'b1);
    beat(32'h80, 1'b1, 32'hFFFFFFFF, 1'b1);
    drain();
    chk("cfg_fcnt", frame_cnt, exp_fc);

    // Back-to-back single-beat frames with different modes.
    cfg_mode = 2'd0;
    beat(32'h33, 1'b1, 32'h33, 1'b1);
    cfg_mode = 2'd2;
    beat(32'h33, 1'b1, ~32'h33, 1'b1);
    drain();
    chk("single_fcnt", frame_cnt, exp_fc);

    // Mid-frame reset with beats buffered: nothing survives.
    cfg_mode = 2'd0;
    m_if.busy = 1'b1;
    for (int i = 0; i < 3; i++) beat(32'h900 + i, 1'b0, 32'h0, 1'b0);
    chk("pre_rst_valid", m_if.valid, 1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("mrst_valid", m_if.valid, 0);
    chk("mrst_data", m_if.data, 0);
    chk("mrst_last", m_if.last, 0);
    chk("mrst_busy", s_if.busy, 0);
    chk("mrst_fcnt", frame_cnt, 0);
    chk("mrst_ovf", overflow, 0);
    exp_fc = 0;
    m_if.busy = 1'b0;
    repeat (6) tick();
    chk("mrst_no_emit", m_if.valid, 0);
    cfg_mode = 2'd2;
    beat(32'h0, 1'b1, 32'hFFFFFFFF, 1'b1);
    drain();
    chk("mrst_fcnt_after", frame_cnt, exp_fc);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=timeout required=finish");
    $fatal(1, "timeout");
  end
endmodule
